// File: rtl/memarb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package memarb_pkg;

  localparam int unsigned MEMARB_PERF_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first set request bit at or after ptr, wrapping to 0.
module rr_picker
  import memarb_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   index,
  output logic            valid
);

  always_comb begin
    int unsigned j;
    j      = 0;
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!valid && req[IW'(j)]) begin
        valid            = 1'b1;
        index            = IW'(j);
        winner[IW'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared 8-bit data-memory port with lock and hold-time revoke.
// Optional per-requester perf counters when MEMARB_PERF_CNT_EN is defined.
module mem_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned AW       = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           lock,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ*AW-1:0]        addr,
  input  logic [NREQ*8-1:0]         wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [AW-1:0]             mem_addr,
  output logic [7:0]                mem_wdata,
  output logic                      mem_we,
  output logic [NREQ-1:0]           rvalid,
  output logic [idx_w(NREQ)-1:0]    owner,
  output logic                      busy
`ifdef MEMARB_PERF_CNT_EN
  ,
  output logic [NREQ*MEMARB_PERF_W-1:0] perf_grants,
  output logic [NREQ*MEMARB_PERF_W-1:0] perf_waits
`endif
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LIM = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  arb_state_t      state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rvalid_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [HW-1:0]   hold_q;
  logic            busy_q;

  logic [NREQ-1:0] others;
  logic [IW-1:0]   ptr_inc;
  logic [IW-1:0]   pick_ptr;
  logic [NREQ-1:0] pick_winner;
  logic [IW-1:0]   pick_index;
  logic            pick_valid;
  logic            req_own;
  logic            lock_own;
  logic            hold_full;
  logic            release_own;
  logic            revoke;
  logic            take;

  // In IDLE gnt_q is zero, so 'others' is the full request vector.
  assign others      = req & ~gnt_q;
  assign req_own     = |(req & gnt_q);
  assign lock_own    = |(lock & gnt_q);
  assign ptr_inc     = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
  assign pick_ptr    = (state_q == IDLE) ? rr_ptr_q : ptr_inc;
  assign hold_full   = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);
  assign release_own = (state_q == GRANT) && !req_own;
  assign revoke      = (state_q == GRANT) && req_own && hold_full && !lock_own && pick_valid;
  assign take        = pick_valid && ((state_q == IDLE) || release_own || revoke);

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req    (others),
    .ptr    (pick_ptr),
    .winner (pick_winner),
    .index  (pick_index),
    .valid  (pick_valid)
  );

  // Arbitration FSM with ownership, pointer, hold counter and read-tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      rvalid_q <= gnt_q & req & ~we;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= GRANT;
            gnt_q   <= pick_winner;
            owner_q <= pick_index;
            busy_q  <= 1'b1;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (release_own || revoke) begin
            rr_ptr_q <= ptr_inc;
            hold_q   <= '0;
            if (pick_valid) begin
              gnt_q   <= pick_winner;
              owner_q <= pick_index;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              owner_q <= '0;
              busy_q  <= 1'b0;
            end
          end else if ((MAX_HOLD != 0) && !hold_full) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory-side steering follows the registered owner with the owner's live beat inputs.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        mem_addr  = addr[i*AW +: AW];
        mem_wdata = wdata[i*8 +: 8];
      end
    end
  end

  assign mem_we = |(we & req & gnt_q);
  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign owner  = owner_q;
  assign busy   = busy_q;

`ifdef MEMARB_PERF_CNT_EN
  logic [MEMARB_PERF_W-1:0] grants_q [NREQ];
  logic [MEMARB_PERF_W-1:0] waits_q  [NREQ];

  // Saturating per-requester grant and wait counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        grants_q[i] <= '0;
        waits_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (take && pick_winner[i] && (grants_q[i] != '1))
          grants_q[i] <= grants_q[i] + MEMARB_PERF_W'(1);
        if (req[i] && !gnt_q[i] && (waits_q[i] != '1))
          waits_q[i] <= waits_q[i] + MEMARB_PERF_W'(1);
      end
    end
  end

  always_comb begin
    perf_grants = '0;
    perf_waits  = '0;
    for (int i = 0; i < NREQ; i++) begin
      perf_grants[i*MEMARB_PERF_W +: MEMARB_PERF_W] = grants_q[i];
      perf_waits[i*MEMARB_PERF_W +: MEMARB_PERF_W]  = waits_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against an ownership model.
module tb_mem_arbiter;

  localparam int unsigned NREQ     = 3;
  localparam int unsigned AW       = 8;
  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned IW       = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req, lock, we;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*8-1:0]    wdata;
  logic [NREQ-1:0]      gnt;
  logic [AW-1:0]        mem_addr;
  logic [7:0]           mem_wdata;
  logic                 mem_we;
  logic [NREQ-1:0]      rvalid;
  logic [IW-1:0]        owner;
  logic                 busy;
`ifdef MEMARB_PERF_CNT_EN
  logic [NREQ*16-1:0]   perf_grants, perf_waits;
`endif

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .rvalid    (rvalid),
    .owner     (owner),
    .busy      (busy)
`ifdef MEMARB_PERF_CNT_EN
    ,
    .perf_grants (perf_grants),
    .perf_waits  (perf_waits)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 idle), rr pointer, cycles owned so far, pending read tags.
  int              m_owner;
  int              m_ptr;
  int              m_held;
  logic [NREQ-1:0] m_rvalid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (((r >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  function automatic bit bitof(input logic [NREQ-1:0] v, input int i);
    return ((v >> i) & 1) != 0;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_held   = 0;
    m_rvalid = '0;
  endtask

  task automatic model_check();
    logic [NREQ-1:0] e_gnt;
    logic [AW-1:0]   e_addr;
    logic [7:0]      e_wdata;
    logic            e_we;
    e_gnt = '0; e_addr = '0; e_wdata = '0; e_we = 1'b0;
    if (m_owner >= 0) begin
      e_gnt   = NREQ'(1) << m_owner;
      e_addr  = addr[m_owner*AW +: AW];
      e_wdata = wdata[m_owner*8 +: 8];
      e_we    = bitof(we, m_owner) && bitof(req, m_owner);
    end
    chk("gnt",       32'(gnt),       32'(e_gnt));
    chk("owner",     32'(owner),     (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("busy",      32'(busy),      32'(m_owner >= 0));
    chk("mem_addr",  32'(mem_addr),  32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("mem_we",    32'(mem_we),    32'(e_we));
    chk("rvalid",    32'(rvalid),    32'(m_rvalid));
  endtask

  task automatic model_step();
    logic [NREQ-1:0] oth;
    m_rvalid = '0;
    if (m_owner >= 0 && bitof(req, m_owner) && !bitof(we, m_owner))
      m_rvalid = NREQ'(1) << m_owner;
    if (m_owner < 0) begin
      m_owner = pick(req, m_ptr);
      m_held  = 1;
    end else if (!bitof(req, m_owner)) begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = pick(req, m_ptr);
      m_held  = 1;
    end else begin
      oth = req & ~(NREQ'(1) << m_owner);
      if (MAX_HOLD != 0 && m_held >= MAX_HOLD && oth != '0 && !bitof(lock, m_owner)) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = pick(oth, m_ptr);
        m_held  = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1;
    model_check();
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_gnt",    32'(gnt),      32'd0);
    chk("rst_rvalid", 32'(rvalid),   32'd0);
    chk("rst_busy",   32'(busy),     32'd0);
    chk("rst_owner",  32'(owner),    32'd0);
    chk("rst_addr",   32'(mem_addr), 32'd0);
    chk("rst_we",     32'(mem_we),   32'd0);
    rst_n = 1'b1;

    // Idle entry with a write beat
    req = 3'b001; we = 3'b001; addr[7:0] = 8'h11; wdata[7:0] = 8'hA5;
    step();
    chk("idle_gnt",   32'(gnt),       32'h1);
    chk("idle_we",    32'(mem_we),    32'h1);
    chk("idle_addr",  32'(mem_addr),  32'h11);
    chk("idle_wdata", 32'(mem_wdata), 32'hA5);

    // Contention: requester 0 holds for 4 cycles, last beat a read at 0x20, then revoked
    req = 3'b011; we = 3'b010; addr[7:0] = 8'h20; addr[15:8] = 8'h33; wdata[15:8] = 8'h5A;
    repeat (3) step();
    chk("hold_gnt", 32'(gnt), 32'h1);
    step();
    chk("revoke_gnt",    32'(gnt),      32'h2);
    chk("revoke_rvalid", 32'(rvalid),   32'h1);
    chk("revoke_owner",  32'(owner),    32'h1);
    chk("revoke_addr",   32'(mem_addr), 32'h33);
    chk("revoke_we",     32'(mem_we),   32'h1);

    // Lock defers revoke past the hold limit
    lock = 3'b010;
    repeat (6) step();
    chk("lock_gnt", 32'(gnt), 32'h2);
    lock = 3'b000;
    step();
    chk("unlock_gnt", 32'(gnt), 32'h1);

    // Release hands off with no idle gap, then empty release goes idle
    req = 3'b010;
    step();
    chk("handoff_gnt", 32'(gnt), 32'h2);
    req = 3'b000;
    step();
    chk("idle_again_gnt",  32'(gnt),  32'h0);
    chk("idle_again_busy", 32'(busy), 32'h0);

    // Pointer sits at 2 after owner 1 released; winner wraps to 0
    req = 3'b011;
    step();
    chk("rr_wrap_gnt", 32'(gnt), 32'h1);

    // Reset mid-grant with a read tag in flight
    req = 3'b001; we = 3'b000; addr[7:0] = 8'h44;
    step();
    chk("pre_rst_rvalid", 32'(rvalid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt",    32'(gnt),      32'h0);
    chk("mid_rst_rvalid", 32'(rvalid),   32'h0);
    chk("mid_rst_busy",   32'(busy),     32'h0);
    chk("mid_rst_owner",  32'(owner),    32'h0);
    chk("mid_rst_addr",   32'(mem_addr), 32'h0);
    chk("mid_rst_we",     32'(mem_we),   32'h0);
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bitof(req, i)) begin
          if (m_owner == i) req[i] = ($urandom_range(0, 5) != 0);
          else              req[i] = ($urandom_range(0, 19) != 0);
        end else begin
          req[i] = ($urandom_range(0, 2) == 0);
        end
        lock[i] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 49) == 0) req = '0;
      we    = NREQ'($urandom);
      addr  = (NREQ*AW)'($urandom);
      wdata = (NREQ*8)'($urandom);
      step();
    end

`ifdef MEMARB_PERF_CNT_EN
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req = 3'b001;
    step();
    req = 3'b011;
    step();
    step();
    req = 3'b010;
    step();
    chk("perf_waits1",  32'(perf_waits[16 +: 16]),  32'd3);
    chk("perf_grants1", 32'(perf_grants[16 +: 16]), 32'd1);
    chk("perf_waits0",  32'(perf_waits[0 +: 16]),   32'd1);
    chk("perf_grants0", 32'(perf_grants[0 +: 16]),  32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
